// File: rtl/irq_ctrl_if.sv
// Chip-select register bus shared with the timer: four 8-bit registers.
// The bus master (CPU side) drives the access, and the slave returns the registered read data.
interface irq_ctrl_if;
  logic [7:0] dbw;
  logic [7:0] dbr;
  logic [1:0] addr;
  logic       cs;
  logic       we;

  modport master (output dbw, addr, cs, we, input dbr);
  modport slave  (input dbw, addr, cs, we, output dbr);
endinterface

// File: rtl/irq_ctrl.sv
// 8-source interrupt controller with pending/enable/mode registers.
// Edge or level latching per source feeds a single registered irq to the CPU.
module irq_ctrl #(
  parameter int NSRC        = 8,
  parameter int SYNC_STAGES = 0
) (
  input  logic            clk,
  input  logic            rst,
  irq_ctrl_if.slave       bus,
  input  logic [NSRC-1:0] src_i,
  output logic            irq_o
);

  typedef enum logic [1:0] {
    REG_PEND   = 2'd0,
    REG_ENABLE = 2'd1,
    REG_MODE   = 2'd2,
    REG_SOFT   = 2'd3
  } reg_addr_e;

  logic [NSRC-1:0] src_s;
  logic [NSRC-1:0] src_prev_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] en_q, en_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [7:0]      dbr_q, dbr_d;
  logic            irq_q;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] edge_evt, clr_mask, set_mask;
  logic [2:0]      idx;
  logic            wr_en, rd_en;

  if (SYNC_STAGES == 2) begin : g_sync
    logic [NSRC-1:0] meta_q, sync_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_q <= '0;
        sync_q <= '0;
      end else begin
        meta_q <= src_i;
        sync_q <= meta_q;
      end
    end
    assign src_s = sync_q;
  end else begin : g_nosync
    assign src_s = src_i;
  end

  assign wr_en    = bus.cs & bus.we;
  assign rd_en    = bus.cs & ~bus.we;
  assign edge_evt = src_s & ~src_prev_q;
  assign clr_mask = (wr_en && bus.addr == REG_PEND) ? bus.dbw : '0;
  assign set_mask = (wr_en && bus.addr == REG_SOFT) ? bus.dbw : '0;
  assign active   = pend_q & en_q;

  // Lowest-numbered enabled pending source; scanned downward so bit 0 wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a path that skips it infers a latch.
    idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) idx = 3'(i);
    end
  end

  // Level bits follow the source; edge bits are sticky, and a hardware edge beats a same-cycle clear.
  always_comb begin
    pend_d = (mode_q & src_s) | (~mode_q & ((pend_q & ~clr_mask) | set_mask | edge_evt));
    en_d   = (wr_en && bus.addr == REG_ENABLE) ? bus.dbw : en_q;
    mode_d = (wr_en && bus.addr == REG_MODE)   ? bus.dbw : mode_q;
    dbr_d  = dbr_q;
    if (rd_en) begin
      unique case (reg_addr_e'(bus.addr))
        REG_PEND:   dbr_d = pend_q;
        REG_ENABLE: dbr_d = en_q;
        REG_MODE:   dbr_d = mode_q;
        REG_SOFT:   dbr_d = {|active, 4'b0, idx};
        default:    dbr_d = dbr_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      pend_q     <= '0;
      en_q       <= '0;
      mode_q     <= '0;
      src_prev_q <= '0;
      dbr_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      src_prev_q <= src_s;
      dbr_q      <= dbr_d;
      irq_q      <= |active;
    end
  end

  assign bus.dbr = dbr_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: one unsynchronised and one 2-stage-synchronised instance,
// driven from a per-cycle vector table plus hand-written reset sequences.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] src0 = '0;
  logic [7:0] src2 = '0;
  logic       irq0, irq2;

  irq_ctrl_if bus0 ();
  irq_ctrl_if bus2 ();

  irq_ctrl #(.NSRC(8), .SYNC_STAGES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .src_i(src0), .irq_o(irq0));
  irq_ctrl #(.NSRC(8), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .src_i(src2), .irq_o(irq2));

  always #5 clk = ~clk;

  typedef struct {
    bit         sel;      // 0: SYNC_STAGES=0 instance, 1: SYNC_STAGES=2 instance
    bit         cs;
    bit         we;
    logic [1:0] addr;
    logic [7:0] dbw;
    logic [7:0] src;
    logic [7:0] exp_dbr;  // dbr after the edge (held value when not reading)
    bit         exp_irq;  // irq after the edge
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t wr(input bit sel, input logic [1:0] a, input logic [7:0] d,
                              input logic [7:0] s, input logic [7:0] edbr, input bit eirq);
    vec_t v;
    v = '{sel, 1'b1, 1'b1, a, d, s, edbr, eirq};
    return v;
  endfunction

  function automatic vec_t rd(input bit sel, input logic [1:0] a, input logic [7:0] s,
                              input logic [7:0] edbr, input bit eirq);
    vec_t v;
    v = '{sel, 1'b1, 1'b0, a, 8'h00, s, edbr, eirq};
    return v;
  endfunction

  function automatic vec_t idle(input bit sel, input logic [7:0] s,
                                input logic [7:0] edbr, input bit eirq);
    vec_t v;
    v = '{sel, 1'b0, 1'b0, 2'd0, 8'h00, s, edbr, eirq};
    return v;
  endfunction

  // Drive one bus cycle on the selected instance at the falling edge; return 1 ns after the rising edge.
  task automatic do_cycle(input vec_t v);
    @(negedge clk);
    if (v.sel) begin
      bus2.cs = v.cs; bus2.we = v.we; bus2.addr = v.addr; bus2.dbw = v.dbw; src2 = v.src;
    end else begin
      bus0.cs = v.cs; bus0.we = v.we; bus0.addr = v.addr; bus0.dbw = v.dbw; src0 = v.src;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus0.cs = 0; bus0.we = 0; bus0.addr = 0; bus0.dbw = 0;
    bus2.cs = 0; bus2.we = 0; bus2.addr = 0; bus2.dbw = 0;

    // Reset state
    vecs.push_back(rd(0, 2'd0, 8'h00, 8'h00, 0));
    vecs.push_back(rd(0, 2'd1, 8'h00, 8'h00, 0));
    vecs.push_back(rd(0, 2'd2, 8'h00, 8'h00, 0));
    vecs.push_back(rd(0, 2'd3, 8'h00, 8'h00, 0));
    // Edge latch and clear
    vecs.push_back(wr(0, 2'd1, 8'h01, 8'h00, 8'h00, 0));
    vecs.push_back(idle(0, 8'h01, 8'h00, 0));            // edge k: pending set
    vecs.push_back(idle(0, 8'h00, 8'h00, 1));            // k+1: irq high
    vecs.push_back(rd(0, 2'd0, 8'h00, 8'h01, 1));
    vecs.push_back(rd(0, 2'd3, 8'h00, 8'h80, 1));
    vecs.push_back(wr(0, 2'd0, 8'h01, 8'h00, 8'h80, 1));
    vecs.push_back(idle(0, 8'h00, 8'h80, 0));
    vecs.push_back(rd(0, 2'd0, 8'h00, 8'h00, 0));
    // Priority and masking
    vecs.push_back(wr(0, 2'd1, 8'h0C, 8'h00, 8'h00, 0));
    vecs.push_back(idle(0, 8'h0E, 8'h00, 0));
    vecs.push_back(idle(0, 8'h00, 8'h00, 1));
    vecs.push_back(rd(0, 2'd3, 8'h00, 8'h82, 1));
    vecs.push_back(wr(0, 2'd0, 8'h04, 8'h00, 8'h82, 1));
    vecs.push_back(rd(0, 2'd3, 8'h00, 8'h83, 1));
    vecs.push_back(wr(0, 2'd1, 8'h00, 8'h00, 8'h83, 1));
    vecs.push_back(idle(0, 8'h00, 8'h83, 0));
    vecs.push_back(rd(0, 2'd0, 8'h00, 8'h0A, 0));
    vecs.push_back(wr(0, 2'd0, 8'h0A, 8'h00, 8'h0A, 0));
    // Level mode
    vecs.push_back(wr(0, 2'd2, 8'h10, 8'h00, 8'h0A, 0));
    vecs.push_back(wr(0, 2'd1, 8'h10, 8'h00, 8'h0A, 0));
    vecs.push_back(idle(0, 8'h10, 8'h0A, 0));
    vecs.push_back(idle(0, 8'h10, 8'h0A, 1));
    vecs.push_back(wr(0, 2'd0, 8'h10, 8'h10, 8'h0A, 1));
    vecs.push_back(rd(0, 2'd0, 8'h10, 8'h10, 1));
    vecs.push_back(idle(0, 8'h00, 8'h10, 1));
    vecs.push_back(idle(0, 8'h00, 8'h10, 0));
    vecs.push_back(rd(0, 2'd0, 8'h00, 8'h00, 0));
    // Collision, soft-set, soft-set on a level bit
    vecs.push_back(wr(0, 2'd2, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(wr(0, 2'd0, 8'h20, 8'h20, 8'h00, 0));
    vecs.push_back(rd(0, 2'd0, 8'h20, 8'h20, 0));
    vecs.push_back(wr(0, 2'd0, 8'h20, 8'h20, 8'h20, 0));
    vecs.push_back(rd(0, 2'd0, 8'h00, 8'h00, 0));
    vecs.push_back(wr(0, 2'd3, 8'h40, 8'h00, 8'h00, 0));
    vecs.push_back(rd(0, 2'd0, 8'h00, 8'h40, 0));
    vecs.push_back(wr(0, 2'd0, 8'h40, 8'h00, 8'h40, 0));
    vecs.push_back(wr(0, 2'd2, 8'h40, 8'h00, 8'h40, 0));
    vecs.push_back(wr(0, 2'd3, 8'h40, 8'h00, 8'h40, 0));
    vecs.push_back(rd(0, 2'd0, 8'h00, 8'h00, 0));
    vecs.push_back(rd(0, 2'd2, 8'h00, 8'h40, 0));
    // Two-stage synchroniser: pending at k+2, irq at k+3, pulse captured once
    vecs.push_back(wr(1, 2'd1, 8'h01, 8'h00, 8'h00, 0));
    vecs.push_back(idle(1, 8'h01, 8'h00, 0));            // edge k
    vecs.push_back(idle(1, 8'h00, 8'h00, 0));            // k+1
    vecs.push_back(idle(1, 8'h00, 8'h00, 0));            // k+2: pending set
    vecs.push_back(idle(1, 8'h00, 8'h00, 1));            // k+3: irq high
    vecs.push_back(rd(1, 2'd0, 8'h00, 8'h01, 1));
    vecs.push_back(wr(1, 2'd0, 8'h01, 8'h00, 8'h01, 1));
    vecs.push_back(idle(1, 8'h00, 8'h01, 0));
    vecs.push_back(idle(1, 8'h00, 8'h01, 0));
    vecs.push_back(idle(1, 8'h00, 8'h01, 0));
    vecs.push_back(rd(1, 2'd0, 8'h00, 8'h00, 0));

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      do_cycle(vecs[i]);
      if (vecs[i].sel) begin
        check($sformatf("v%0d dbr2", i), bus2.dbr, vecs[i].exp_dbr);
        check($sformatf("v%0d irq2", i), {7'b0, irq2}, {7'b0, vecs[i].exp_irq});
      end else begin
        check($sformatf("v%0d dbr0", i), bus0.dbr, vecs[i].exp_dbr);
        check($sformatf("v%0d irq0", i), {7'b0, irq0}, {7'b0, vecs[i].exp_irq});
      end
    end

    // Async reset mid-operation drops irq and dbr without waiting for a clock
    do_cycle(wr(0, 2'd2, 8'h00, 8'h00, 8'h00, 0));
    do_cycle(wr(0, 2'd1, 8'h01, 8'h00, 8'h00, 0));
    do_cycle(wr(0, 2'd3, 8'h01, 8'h00, 8'h00, 0));
    do_cycle(rd(0, 2'd0, 8'h00, 8'h00, 0));
    check("pre-reset irq", {7'b0, irq0}, 8'h01);
    check("pre-reset dbr", bus0.dbr, 8'h01);
    #1 rst = 1'b1;
    #1;
    check("async reset irq", {7'b0, irq0}, 8'h00);
    check("async reset dbr", bus0.dbr, 8'h00);

    // Source held high through reset registers exactly one edge
    @(negedge clk);
    src0 = 8'h01; bus0.cs = 0;
    @(negedge clk);
    rst = 1'b0;
    do_cycle(idle(0, 8'h01, 8'h00, 0));
    do_cycle(rd(0, 2'd0, 8'h01, 8'h00, 0));
    check("held-high edge pend", bus0.dbr, 8'h01);
    do_cycle(wr(0, 2'd0, 8'h01, 8'h01, 8'h00, 0));
    do_cycle(rd(0, 2'd0, 8'h01, 8'h00, 0));
    check("held-high no re-latch", bus0.dbr, 8'h00);
    do_cycle(rd(0, 2'd1, 8'h01, 8'h00, 0));
    check("enable after reset", bus0.dbr, 8'h00);
    check("irq after reset", {7'b0, irq0}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
